// File: rtl/vga_axil_pkg.sv
// Shared widths, types and helpers for the VGA AXI4-Lite front end.
package vga_axil_pkg;

    localparam int AXIL_ADDR_WIDTH   = 32;
    localparam int AXIL_DATA_WIDTH   = 32;
    localparam int AXIL_WIDTH_OFFSET = 2;
    localparam int NATIVE_ADDR_WIDTH = AXIL_ADDR_WIDTH - AXIL_WIDTH_OFFSET;

    typedef logic [AXIL_ADDR_WIDTH-1:0]   axil_addr_t;
    typedef logic [AXIL_DATA_WIDTH-1:0]   axil_data_t;
    typedef logic [NATIVE_ADDR_WIDTH-1:0] native_addr_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_STROBE,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_STROBE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    // Byte address to native word address; the in-word byte offset is dropped.
    function automatic native_addr_t axil2native_addr(input axil_addr_t addr);
        return native_addr_t'(addr >> AXIL_WIDTH_OFFSET);
    endfunction

endpackage

// File: rtl/vga_axil_if.sv
// AXI4-Lite bus between the system interconnect (master) and the VGA front end (slave).
interface vga_axil_if;
    import vga_axil_pkg::*;

    axil_addr_t awaddr;
    logic       awvalid;
    logic       awready;
    axil_data_t wdata;
    logic [3:0] wstrb;
    logic       wvalid;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready;
    axil_addr_t araddr;
    logic       arvalid;
    logic       arready;
    axil_data_t rdata;
    logic [1:0] rresp;
    logic       rvalid;
    logic       rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/vga_native_if.sv
// Native strobe bus from the AXI-Lite front end (master) to the VGA register file (slave).
interface vga_native_if;
    import vga_axil_pkg::*;

    logic         write_en;
    native_addr_t addr_write;
    axil_data_t   data2native;
    logic         read_en_sync;
    native_addr_t addr_read;
    axil_data_t   data2axil;

    modport master (
        output write_en, addr_write, data2native, read_en_sync, addr_read,
        input  data2axil
    );

    modport slave (
        input  write_en, addr_write, data2native, read_en_sync, addr_read,
        output data2axil
    );

endinterface

// File: rtl/vga_axil_wr_fsm.sv
// AXI-Lite write channels to a one-cycle native write strobe; strobe the cycle after both AW and W land,
// response the cycle after that. One write outstanding; AW/W ready stay low until B is accepted.
module vga_axil_wr_fsm
    import vga_axil_pkg::*;
(
    input  logic         clk,
    input  logic         arst_n,
    input  axil_addr_t   awaddr,
    input  logic         awvalid,
    output logic         awready,
    input  axil_data_t   wdata,
    input  logic         wvalid,
    output logic         wready,
    output logic [1:0]   bresp,
    output logic         bvalid,
    input  logic         bready,
    output logic         write_en,
    output native_addr_t addr_write,
    output axil_data_t   data2native
);

    wr_state_e    state_q, state_d;
    logic         aw_got_q, aw_got_d;
    logic         w_got_q, w_got_d;
    logic         awready_q, awready_d;
    logic         wready_q, wready_d;
    logic         bvalid_q, bvalid_d;
    logic         write_en_q, write_en_d;
    native_addr_t addr_q, addr_d;
    axil_data_t   data_q, data_d;

    logic aw_hs, w_hs, aw_done, w_done;

    assign aw_hs   = awvalid && awready_q;
    assign w_hs    = wvalid && wready_q;
    assign aw_done = aw_got_q || aw_hs;
    assign w_done  = w_got_q || w_hs;

    always_comb begin
        state_d    = state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = bvalid_q;
        write_en_d = 1'b0;
        addr_d     = aw_hs ? axil2native_addr(awaddr) : addr_q;
        data_d     = w_hs ? wdata : data_q;
        case (state_q)
            W_IDLE: begin
                // Each channel is captured on its own; ready drops only for the one already held.
                if (aw_done && w_done) begin
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    write_en_d = 1'b1;
                    state_d    = W_STROBE;
                end else begin
                    aw_got_d  = aw_done;
                    w_got_d   = w_done;
                    awready_d = !aw_done;
                    wready_d  = !w_done;
                end
            end
            W_STROBE: begin
                bvalid_d = 1'b1;
                state_d  = W_RESP;
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    state_d   = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            write_en_q <= write_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign awready     = awready_q;
    assign wready      = wready_q;
    assign bvalid      = bvalid_q;
    assign bresp       = OKAY;
    assign write_en    = write_en_q;
    assign addr_write  = addr_q;
    assign data2native = data_q;

endmodule

// File: rtl/vga_axil_slave_fsm.sv
// AXI4-Lite slave front end for the VGA register space: write path in vga_axil_wr_fsm, read path here.
// Read: strobe, one cycle for native data, then R held until rready; one read outstanding.
module vga_axil_slave_fsm
    import vga_axil_pkg::*;
(
    input  logic         clk,
    input  logic         arst_n,
    vga_axil_if.slave    axil,
    vga_native_if.master native
);

    vga_axil_wr_fsm u_wr_fsm (
        .clk         (clk),
        .arst_n      (arst_n),
        .awaddr      (axil.awaddr),
        .awvalid     (axil.awvalid),
        .awready     (axil.awready),
        .wdata       (axil.wdata),
        .wvalid      (axil.wvalid),
        .wready      (axil.wready),
        .bresp       (axil.bresp),
        .bvalid      (axil.bvalid),
        .bready      (axil.bready),
        .write_en    (native.write_en),
        .addr_write  (native.addr_write),
        .data2native (native.data2native)
    );

    // Byte strobes are not supported by the register file; every write is a full word.
    logic unused_wstrb;
    assign unused_wstrb = ^axil.wstrb;

    rd_state_e    rd_state_q, rd_state_d;
    logic         arready_q, arready_d;
    logic         read_en_q, read_en_d;
    logic         rvalid_q, rvalid_d;
    native_addr_t addr_read_q, addr_read_d;
    axil_data_t   rdata_q, rdata_d;

    always_comb begin
        rd_state_d  = rd_state_q;
        arready_d   = 1'b0;
        read_en_d   = 1'b0;
        rvalid_d    = rvalid_q;
        addr_read_d = addr_read_q;
        rdata_d     = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (axil.arvalid && arready_q) begin
                    addr_read_d = axil2native_addr(axil.araddr);
                    read_en_d   = 1'b1;
                    rd_state_d  = R_STROBE;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_STROBE: rd_state_d = R_WAIT;
            R_WAIT: begin
                rdata_d    = native.data2axil;
                rvalid_d   = 1'b1;
                rd_state_d = R_RESP;
            end
            R_RESP: begin
                if (axil.rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_state_q  <= R_IDLE;
            arready_q   <= 1'b0;
            read_en_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            addr_read_q <= '0;
            rdata_q     <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            arready_q   <= arready_d;
            read_en_q   <= read_en_d;
            rvalid_q    <= rvalid_d;
            addr_read_q <= addr_read_d;
            rdata_q     <= rdata_d;
        end
    end

    assign axil.arready        = arready_q;
    assign axil.rvalid         = rvalid_q;
    assign axil.rdata          = rdata_q;
    assign axil.rresp          = OKAY;
    assign native.read_en_sync = read_en_q;
    assign native.addr_read    = addr_read_q;

endmodule

// File: tb/tb_vga_axil_slave_fsm.sv
// Scoreboard bench for vga_axil_slave_fsm: a word-array reference model feeds expectation queues,
// a negedge monitor pops and compares native strobes and AXI responses.
module tb_vga_axil_slave_fsm;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;

    vga_axil_if   axil();
    vga_native_if native();

    vga_axil_slave_fsm dut (
        .clk    (clk),
        .arst_n (arst_n),
        .axil   (axil),
        .native (native)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit in_rst = 1'b1;
    bit traffic_done;
    int ws_cnt = 0;
    int rs_cnt = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] reg_mem [256];
    logic [61:0] exp_ws [$];
    logic [29:0] exp_rs [$];
    logic [31:0] exp_r  [$];
    logic [1:0]  exp_b  [$];

    // Register file stand-in: read data is only meaningful in the cycle after the strobe.
    always @(posedge clk) begin
        if (native.write_en) reg_mem[native.addr_write[7:0]] <= native.data2native;
        native.data2axil <= native.read_en_sync ? reg_mem[native.addr_read[7:0]] : ($urandom | 32'h8000_0001);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected DUT handshake", name);
    endtask

    function automatic logic [6:0] ctl_outs();
        return {axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid,
                native.write_en, native.read_en_sync};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int k);
        for (int i = 0; i < k && !in_rst; i++) step();
    endtask

    task automatic drive_aw(input logic [31:0] a);
        int n = 0;
        step();
        if (in_rst) return;
        axil.awaddr  = a;
        axil.awvalid = 1'b1;
        while (!axil.awready && !in_rst && n < 100) begin step(); n++; end
        if (n >= 100) timeout("aw_handshake");
        step();
        axil.awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d);
        int n = 0;
        step();
        if (in_rst) return;
        axil.wdata  = d;
        axil.wstrb  = 4'($urandom);
        axil.wvalid = 1'b1;
        while (!axil.wready && !in_rst && n < 100) begin step(); n++; end
        if (n >= 100) timeout("w_handshake");
        step();
        axil.wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] a);
        int n = 0;
        step();
        if (in_rst) return;
        axil.araddr  = a;
        axil.arvalid = 1'b1;
        while (!axil.arready && !in_rst && n < 100) begin step(); n++; end
        if (n >= 100) timeout("ar_handshake");
        step();
        axil.arvalid = 1'b0;
    endtask

    task automatic wait_b(input int dly);
        int n = 0;
        while (!axil.bvalid && !in_rst && n < 100) begin step(); n++; end
        if (n >= 100) timeout("b_valid");
        gap(dly);
        if (in_rst) return;
        axil.bready = 1'b1;
        step();
        axil.bready = 1'b0;
    endtask

    task automatic wait_r(input int dly);
        int n = 0;
        while (!axil.rvalid && !in_rst && n < 100) begin step(); n++; end
        if (n >= 100) timeout("r_valid");
        gap(dly);
        if (in_rst) return;
        axil.rready = 1'b1;
        step();
        axil.rready = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int order, input int bdly);
        if (in_rst) return;
        exp_ws.push_back({a[31:2], d});
        exp_b.push_back(2'b00);
        ref_mem[a[9:2]] = d;
        case (order)
            0: fork
                drive_aw(a);
                drive_w(d);
            join
            1: begin drive_aw(a); drive_w(d); end
            default: begin drive_w(d); drive_aw(a); end
        endcase
        wait_b(bdly);
    endtask

    task automatic do_read(input logic [31:0] a, input int rdly);
        if (in_rst) return;
        exp_rs.push_back(a[31:2]);
        exp_r.push_back(ref_mem[a[9:2]]);
        drive_ar(a);
        wait_r(rdly);
    endtask

    task automatic random_traffic(input int n);
        logic [31:0] wl [$];
        logic [31:0] a;
        for (int i = 0; i < n && !in_rst; i++) begin
            a = $urandom;
            do_write(a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
            wl.push_back(a);
            gap($urandom_range(0, 10));
            a = wl[$urandom_range(0, wl.size() - 1)];
            a[1:0] = 2'($urandom);
            do_read(a, $urandom_range(0, 3));
            gap($urandom_range(0, 10));
        end
    endtask

    // Monitor: samples mid-cycle, a valid&&ready seen here completes on the next rising edge.
    initial begin
        logic pb_v = 1'b0, pb_r = 1'b0, pr_v = 1'b0, pr_r = 1'b0;
        logic [31:0] pr_d = '0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                pb_v = 1'b0;
                pr_v = 1'b0;
            end else begin
                if (pb_v && !pb_r) check("bvalid_hold", 64'(axil.bvalid), 64'(1));
                if (pr_v && !pr_r) begin
                    check("rvalid_hold", 64'(axil.rvalid), 64'(1));
                    check("rdata_hold", 64'(axil.rdata), 64'(pr_d));
                end
                if (native.write_en) begin
                    ws_cnt++;
                    if (exp_ws.size() == 0) check("write_en_unexpected", 64'(native.write_en), 64'(0));
                    else check("write_strobe", 64'({native.addr_write, native.data2native}), 64'(exp_ws.pop_front()));
                end
                if (native.read_en_sync) begin
                    rs_cnt++;
                    if (exp_rs.size() == 0) check("read_en_unexpected", 64'(native.read_en_sync), 64'(0));
                    else check("read_strobe_addr", 64'(native.addr_read), 64'(exp_rs.pop_front()));
                end
                if (axil.bvalid && axil.bready) begin
                    if (exp_b.size() == 0) check("b_unexpected", 64'(axil.bvalid), 64'(0));
                    else check("bresp", 64'(axil.bresp), 64'(exp_b.pop_front()));
                end
                if (axil.rvalid && axil.rready) begin
                    if (exp_r.size() == 0) check("r_unexpected", 64'(axil.rvalid), 64'(0));
                    else begin
                        check("rdata", 64'(axil.rdata), 64'(exp_r.pop_front()));
                        check("rresp", 64'(axil.rresp), 64'(0));
                    end
                end
                pb_v = axil.bvalid;
                pb_r = axil.bready;
                pr_v = axil.rvalid;
                pr_r = axil.rready;
                pr_d = axil.rdata;
            end
        end
    end

    initial begin
        int ws0, rs0, n;
        logic [31:0] wa, wd, ra;

        axil.awaddr  = '0;
        axil.awvalid = 1'b0;
        axil.wdata   = '0;
        axil.wstrb   = '0;
        axil.wvalid  = 1'b0;
        axil.bready  = 1'b0;
        axil.araddr  = '0;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b0;

        #1 arst_n = 1'b0;
        #2 check("reset_ctl_outs", 64'(ctl_outs()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl_outs_clocked", 64'(ctl_outs()), 64'(0));
        check("reset_addr_write", 64'(native.addr_write), 64'(0));
        check("reset_data2native", 64'(native.data2native), 64'(0));
        check("reset_rdata", 64'(axil.rdata), 64'(0));
        @(negedge clk);
        arst_n = 1'b1;
        in_rst = 1'b0;

        // Continuous: ten writes of addr-as-data, then read them all back.
        ws0 = ws_cnt;
        rs0 = rs_cnt;
        for (int i = 0; i < 10; i++) do_write(32'(4 * i), 32'(4 * i), 0, 0);
        for (int i = 0; i < 10; i++) do_read(32'(4 * i), 0);
        check("cont_write_en_count", 64'(ws_cnt - ws0), 64'(10));
        check("cont_read_en_count", 64'(rs_cnt - rs0), 64'(10));

        // Parallel: a fresh write and a read of preloaded data start in the same cycle.
        for (int k = 0; k < 3; k++) begin
            wa = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(64, 255)) << 2);
            wd = $urandom;
            ra = 32'(4 * $urandom_range(0, 9));
            fork
                do_write(wa, wd, 0, 0);
                do_read(ra, 0);
            join
        end

        // Channel order: W first, AW first, together.
        for (int order = 2; order >= 0; order--) begin
            ws0 = ws_cnt;
            wa = $urandom;
            do_write(wa, $urandom, order, 0);
            check("order_write_en_count", 64'(ws_cnt - ws0), 64'(1));
            do_read(wa, 0);
        end

        // Backpressure on both response channels.
        ws0 = ws_cnt;
        rs0 = rs_cnt;
        wa = $urandom;
        do_write(wa, $urandom, 0, 5);
        do_read(wa, 5);
        check("bp_write_en_count", 64'(ws_cnt - ws0), 64'(1));
        check("bp_read_en_count", 64'(rs_cnt - rs0), 64'(1));

        random_traffic(10);

        // Reset mid-traffic.
        traffic_done = 1'b0;
        fork
            begin
                random_traffic(30);
                traffic_done = 1'b1;
            end
        join_none
        repeat ($urandom_range(10, 60)) step();
        #2;
        in_rst = 1'b1;
        arst_n = 1'b0;
        #1 check("reset_async_outs", 64'(ctl_outs()), 64'(0));
        #($urandom_range(49, 99));
        n = 0;
        while (!traffic_done && n < 20) begin @(negedge clk); n++; end
        if (!traffic_done) timeout("traffic_abort");
        exp_ws.delete();
        exp_rs.delete();
        exp_r.delete();
        exp_b.delete();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.arvalid = 1'b0;
        axil.bready  = 1'b0;
        axil.rready  = 1'b0;
        check("reset_held_outs", 64'(ctl_outs()), 64'(0));
        arst_n = 1'b1;
        in_rst = 1'b0;
        ws0 = ws_cnt;
        rs0 = rs_cnt;
        gap(10);
        check("post_reset_no_write_en", 64'(ws_cnt - ws0), 64'(0));
        check("post_reset_no_read_en", 64'(rs_cnt - rs0), 64'(0));
        random_traffic(10);

        gap(5);
        check("queues_drained", 64'(exp_ws.size() + exp_rs.size() + exp_r.size() + exp_b.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
